spi_simple_master: RTL and testbench
====================================

Name: spi_simple_master

Overview:
Byte-wide SPI master in mode 0 (CPOL=0, CPHA=0), MSB first. This is the controller end of the same link our SPI slave block serves. It accepts one byte per valid/ready handshake, generates sck/cs_n/mosi from the system clock, and returns the byte shifted in on miso. Optional bursts keep cs_n low across consecutive bytes.

Parameters:
CLK_DIV, 4, sck half-period in clk cycles; integer >= 1; sck frequency = clk/(2*CLK_DIV).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
tx_data  input  8  byte to transmit
tx_last  input  1  sampled with tx_data; 1 = deassert cs_n after this byte
tx_valid  input  1  tx_data/tx_last valid
tx_ready  output  1  master can accept a byte this cycle
rx_data  output  8  byte received on miso (registered)
rx_valid  output  1  one-cycle pulse; rx_data is new
sck  output  1  SPI clock, registered, idle low
cs_n  output  1  chip select, registered, active low
mosi  output  1  serial data out, registered
miso  input  1  serial data in

Behaviour:
- Reset (async, any state, including mid-byte): state IDLE; cs_n=1, sck=0, mosi=0, rx_data=0x00, rx_valid=0; tx_ready=1 once reset is released.
- States: IDLE (cs_n=1), XFER (cs_n=0, shifting), HOLD (cs_n=0, between burst bytes).
- tx_ready is combinational and equals 1 in IDLE or HOLD, 0 in XFER.
- Accept: a byte is accepted when tx_valid && tx_ready at a clk edge. On acceptance, tx_data and tx_last are latched internally. Inputs are ignored while tx_ready=0.
- Acceptance at edge t: from t+1, state XFER, cs_n=0, mosi=tx_data[7], sck=0.
- XFER is 17 phases of CLK_DIV cycles each, indexed 0..16. Even phases have sck=0 and odd phases have sck=1.
- Phase 0 is the lead (cs_n-to-first-sck setup).
- Entering an odd phase: sck 0->1, and the same edge shifts miso into the receive shift register LSB-first-in (first sample becomes bit 7 of the byte).
- Entering an even phase 2..14: sck 1->0, and mosi advances to the next lower bit. Entering phase 16: sck 1->0, mosi unchanged.
- Exactly 8 sck rising edges per byte.
- rx_valid=1 with rx_data updated for exactly the first cycle of phase 16, at t+1+16*CLK_DIV. rx_data holds its value until the next update.
- End of phase 16 (t+1+17*CLK_DIV):
  - latched tx_last=1: cs_n=1, mosi=0, state IDLE.
  - latched tx_last=0: state HOLD, cs_n stays 0, sck stays 0.
- HOLD: remains indefinitely until the next accept. The next byte then starts directly at phase 0 with cs_n held low (no cs_n glitch). A burst is closed only by a byte with tx_last=1.
- Accept in IDLE in the cycle right after cs_n rises is legal. Minimum cs_n high time is 1 clk.
- sck, cs_n and mosi change only on clk edges. sck is never high while cs_n=1.
- The divider counter resets to 0 on every phase transition and on accept. CLK_DIV=1 gives sck=clk/2 with the same phase sequence.
- No internal buffering: at most one byte in flight. Back-to-back throughput is 1 byte per 17*CLK_DIV+1 cycles.

Test Plan:
1. Single byte, CLK_DIV=4: tx_data=0xA5, tx_last=1; slave model drives 0x3C.
   -> mosi bits 1,0,1,0,0,1,0,1 at the 8 sck rises; rx_valid pulse at accept+65 with rx_data=0x3C; cs_n=1 at accept+69; tx_ready low for cycles accept+1..accept+68.
2. Burst: 0x12 (tx_last=0) then 0x34 (tx_last=1) offered as soon as tx_ready rises.
   -> cs_n stays 0 across both bytes; 16 sck rises; two rx_valid pulses; cs_n rises after byte 2 only.
3. Busy protection: tx_valid=1 with 0xFF on each cycle mid-transfer of 0x81.
   -> mosi pattern stays 0x81; 0xFF is accepted only after tx_ready returns.
4. Reset mid-byte: assert rst after the 3rd sck rise.
   -> same cycle cs_n=1, sck=0, mosi=0, rx_valid=0; after release tx_ready=1; a new 0xC3 transfer completes correctly.
5. CLK_DIV=1: tx_data=0x5A with loopback miso=mosi.
   -> sck toggles every clk; rx_valid at accept+17; rx_data=0x5A.
6. Back-to-back single bytes 0x01, 0x02 (tx_last=1 each).
   -> cs_n high exactly 1 cycle between bytes; both rx bytes correct.

Source files
------------

// File: rtl/spi_simple_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_simple_master
//  Purpose  : Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//             Accepts one byte per valid/ready handshake, drives sck/cs_n/mosi
//             and returns the byte sampled on miso. Bursts keep cs_n low
//             until a byte flagged tx_last completes.
//  Ports    : clk, rst (async, active high)
//             tx_data[7:0], tx_last, tx_valid -> tx_ready   (byte input)
//             rx_data[7:0], rx_valid                        (byte output)
//             sck, cs_n, mosi (registered), miso            (SPI pins)
//  Revision : 1.0  initial release
// ============================================================================
module spi_simple_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       sck,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [4:0]    LAST_PHASE = 5'd16;

    state_t        state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [4:0]    phase_q,    phase_d;
    logic [7:0]    tx_sr_q,    tx_sr_d;
    logic          last_q,     last_d;
    logic [7:0]    rx_sr_q,    rx_sr_d;
    logic [7:0]    rx_data_q,  rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          sck_q,      sck_d;
    logic          cs_n_q,     cs_n_d;
    logic          mosi_q,     mosi_d;

    logic [4:0]    w_phase_nxt;
    logic          w_accept;

    assign tx_ready    = (state_q != ST_XFER);
    assign w_accept    = tx_valid && tx_ready;
    assign w_phase_nxt = phase_q + 5'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        tx_sr_d    = tx_sr_q;
        last_d     = last_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                // From HOLD cs_n is already low, so a new byte starts with no
                // chip-select glitch.
                if (w_accept) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                    phase_d = 5'd0;
                    tx_sr_d = tx_data;
                    last_d  = tx_last;
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    mosi_d  = tx_data[7];
                end
            end

            ST_XFER: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (phase_q == LAST_PHASE) begin
                        // Trailing half-period done: close or park the burst.
                        if (last_q) begin
                            state_d = ST_IDLE;
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        phase_d = w_phase_nxt;
                        if (w_phase_nxt[0]) begin
                            // Rising sck: sample miso, first sample ends up in bit 7.
                            sck_d   = 1'b1;
                            rx_sr_d = {rx_sr_q[6:0], miso};
                        end else begin
                            sck_d = 1'b0;
                            if (w_phase_nxt != LAST_PHASE) begin
                                tx_sr_d = {tx_sr_q[6:0], 1'b0};
                                mosi_d  = tx_sr_q[6];
                            end else begin
                                // All eight samples are in by the final fall.
                                rx_data_d  = rx_sr_q;
                                rx_valid_d = 1'b1;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            phase_q    <= 5'd0;
            tx_sr_q    <= 8'h00;
            last_q     <= 1'b0;
            rx_sr_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            tx_sr_q    <= tx_sr_d;
            last_q     <= last_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sck      = sck_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_simple_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_simple_master
//  Purpose  : Scoreboard bench for spi_simple_master. One instance runs with
//             CLK_DIV=4 against a mode-0 slave model, a second with CLK_DIV=1
//             in miso=mosi loopback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_simple_master;

    localparam int D4 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CLK_DIV=4 instance
    logic [7:0] tx_data;
    logic       tx_last, tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, sck, cs_n, mosi, miso;

    // CLK_DIV=1 instance
    logic [7:0] tx1_data;
    logic       tx1_last, tx1_valid, tx1_ready;
    logic [7:0] rx1_data;
    logic       rx1_valid, sck1, cs1_n, mosi1, miso1;

    spi_simple_master #(.CLK_DIV(D4)) u_dut4 (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_simple_master #(.CLK_DIV(D1)) u_dut1 (
        .clk(clk), .rst(rst),
        .tx_data(tx1_data), .tx_last(tx1_last), .tx_valid(tx1_valid), .tx_ready(tx1_ready),
        .rx_data(rx1_data), .rx_valid(rx1_valid),
        .sck(sck1), .cs_n(cs1_n), .mosi(mosi1), .miso(miso1)
    );

    assign miso1 = mosi1;

    // Mode-0 slave: presents bit 7 first, moves to the next lower bit on each
    // falling sck; eight falls per byte wrap the 3-bit count back to 0.
    logic [7:0] sl_byte = 8'h00;
    logic [2:0] fall_cnt;
    always @(negedge sck or posedge rst) begin
        if (rst) fall_cnt <= 3'd0;
        else     fall_cnt <= fall_cnt + 3'd1;
    end
    assign miso = sl_byte[3'd7 - fall_cnt];

    // Scoreboard queues
    logic [7:0] e_rx4[$];
    int         e_rxt4[$];
    logic [7:0] e_mo4[$];
    int         e_cs4[$];
    logic [7:0] e_rx1[$];
    int         e_rxt1[$];

    int errors = 0;
    int checks = 0;
    int last_acc = 0;
    int bsy_lo = 0;
    int bsy_hi = 0;
    int rise_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Issue one byte; called at a negedge, returns at the negedge after accept.
    task automatic send(input int sel, input logic [7:0] d, input logic l, input logic [7:0] sl);
        int g = 0;
        int acc;
        if (sel == 0) begin
            tx_valid = 1'b1; tx_data = d; tx_last = l;
            while (!tx_ready) begin
                @(negedge clk);
                g++;
                if (g > 500) begin fail_now("ready_timeout"); tx_valid = 1'b0; return; end
            end
            sl_byte = sl;
            acc = cyc + 1;
            e_rx4.push_back(sl);
            e_rxt4.push_back(acc + 16*D4);
            e_mo4.push_back(d);
            if (l) e_cs4.push_back(acc + 17*D4);
            bsy_lo = acc; bsy_hi = acc + 17*D4;
            last_acc = acc;
            @(negedge clk);
            tx_valid = 1'b0;
        end else begin
            tx1_valid = 1'b1; tx1_data = d; tx1_last = l;
            while (!tx1_ready) begin
                @(negedge clk);
                g++;
                if (g > 500) begin fail_now("ready1_timeout"); tx1_valid = 1'b0; return; end
            end
            acc = cyc + 1;
            e_rx1.push_back(d);
            e_rxt1.push_back(acc + 16*D1);
            last_acc = acc;
            @(negedge clk);
            tx1_valid = 1'b0;
        end
    endtask

    task automatic monitor();
        logic sck_p = 1'b0;
        logic cs_p  = 1'b1;
        logic [7:0] cap = 8'h00;
        logic [7:0] eb;
        int et;
        forever begin
            @(negedge clk);
            if (rst) begin
                rise_cnt = 0; sck_p = 1'b0; cs_p = 1'b1;
            end else begin
                chk("sck_high_with_cs_high", {31'd0, sck & cs_n}, 32'd0);
                chk("tx_ready_window", {31'd0, tx_ready},
                    {31'd0, !(cyc >= bsy_lo && cyc < bsy_hi)});
                if (sck && !sck_p) begin
                    cap = {cap[6:0], mosi};
                    rise_cnt++;
                    if (rise_cnt == 8) begin
                        rise_cnt = 0;
                        if (e_mo4.size() == 0) fail_now("unexpected_mosi_byte");
                        else begin eb = e_mo4.pop_front(); chk("mosi_byte", {24'd0, cap}, {24'd0, eb}); end
                    end
                end
                if (rx_valid) begin
                    if (e_rx4.size() == 0) fail_now("unexpected_rx_valid");
                    else begin
                        eb = e_rx4.pop_front(); et = e_rxt4.pop_front();
                        chk("rx_data", {24'd0, rx_data}, {24'd0, eb});
                        chk("rx_valid_cycle", cyc, et);
                    end
                end
                if (cs_n && !cs_p) begin
                    if (e_cs4.size() == 0) fail_now("unexpected_cs_n_rise");
                    else begin et = e_cs4.pop_front(); chk("cs_n_rise_cycle", cyc, et); end
                end
                if (rx1_valid) begin
                    if (e_rx1.size() == 0) fail_now("unexpected_rx1_valid");
                    else begin
                        eb = e_rx1.pop_front(); et = e_rxt1.pop_front();
                        chk("rx1_data", {24'd0, rx1_data}, {24'd0, eb});
                        chk("rx1_valid_cycle", cyc, et);
                    end
                end
                sck_p = sck;
                cs_p  = cs_n;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int g;
        logic [7:0] rd, rs;
        logic rl;
        tx_valid = 1'b0;  tx_data = 8'h00;  tx_last = 1'b0;
        tx1_valid = 1'b0; tx1_data = 8'h00; tx1_last = 1'b0;
        rst = 1'b1;
        fork monitor(); join_none
        repeat (3) @(negedge clk);

        chk("reset_cs_n", {31'd0, cs_n}, 32'd1);
        chk("reset_sck", {31'd0, sck}, 32'd0);
        chk("reset_mosi", {31'd0, mosi}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, tx_ready}, 32'd1);

        // Single byte
        send(0, 8'hA5, 1'b1, 8'h3C);
        repeat (75) @(negedge clk);

        // Burst of two, second offered as soon as ready rises
        send(0, 8'h12, 1'b0, 8'h5E);
        a1 = last_acc;
        send(0, 8'h34, 1'b1, 8'hC7);
        chk("burst_spacing", last_acc - a1, 17*D4 + 1);
        repeat (75) @(negedge clk);

        // Busy protection: 0xFF held valid while 0x81 is in flight
        send(0, 8'h81, 1'b1, 8'h00);
        send(0, 8'hFF, 1'b1, 8'hFF);
        repeat (75) @(negedge clk);

        // Reset after the third sck rise
        send(0, 8'h96, 1'b1, 8'h69);
        g = 0;
        while (rise_cnt != 3 && g < 400) begin @(negedge clk); #1; g++; end
        if (g >= 400) fail_now("third_rise_timeout");
        rst = 1'b1;
        #1;
        chk("midreset_cs_n", {31'd0, cs_n}, 32'd1);
        chk("midreset_sck", {31'd0, sck}, 32'd0);
        chk("midreset_mosi", {31'd0, mosi}, 32'd0);
        chk("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        e_rx4.delete(); e_rxt4.delete(); e_mo4.delete(); e_cs4.delete();
        bsy_lo = 0; bsy_hi = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", {31'd0, tx_ready}, 32'd1);
        send(0, 8'hC3, 1'b1, 8'hA7);
        repeat (75) @(negedge clk);

        // CLK_DIV=1 loopback
        send(1, 8'h5A, 1'b1, 8'h00);
        repeat (25) @(negedge clk);

        // Back-to-back single bytes: cs_n high for exactly one cycle
        send(0, 8'h01, 1'b1, 8'h80);
        a1 = last_acc;
        send(0, 8'h02, 1'b1, 8'h40);
        chk("b2b_spacing", last_acc - a1, 17*D4 + 1);
        repeat (75) @(negedge clk);

        // Randomized traffic, bursts and gaps mixed; final byte closes any burst
        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom); rs = 8'($urandom);
            rl = (i == 19) ? 1'b1 : ($urandom_range(0, 2) == 0);
            send(0, rd, rl, rs);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            rl = (i == 5) ? 1'b1 : ($urandom_range(0, 1) == 0);
            send(1, rd, rl, 8'h00);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (80) @(negedge clk);

        chk("pending_rx", e_rx4.size(), 0);
        chk("pending_mosi", e_mo4.size(), 0);
        chk("pending_cs", e_cs4.size(), 0);
        chk("pending_rx1", e_rx1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
